// File: rtl/event_stream_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : event_stream_tx                                                 |
// | Brief    : Spike-event FIFO with optional sync-byte framing, MSB-byte-     |
// |            first byte handshake to uart_tx, and overflow accounting.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module event_stream_tx #(
    parameter int         EV_W      = 24,
    parameter int         FIFO_AW   = 8,
    parameter bit         SYNC_EN   = 1'b1,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ev_wr,
    input  logic [EV_W-1:0]  ev_data,
    input  logic             clear_drops,
    input  logic             tx_busy,
    output logic             tx_req,
    output logic [7:0]       tx_data,
    output logic             fifo_full,
    output logic [FIFO_AW:0] fifo_level,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count,
    output logic             busy
);

    localparam int c_NB    = (EV_W + 7) / 8;
    localparam int c_SR_W  = c_NB * 8;
    localparam int c_DEPTH = 1 << FIFO_AW;
    localparam int c_IDX_W = $clog2(c_NB + 1);

    localparam logic [FIFO_AW:0]   c_FULL_LEVEL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [CNT_W-1:0]   c_CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [c_IDX_W-1:0] c_LAST_IDX   = c_IDX_W'(c_NB);
    localparam logic [c_IDX_W-1:0] c_FIRST_IDX  = SYNC_EN ? '0 : c_IDX_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_SEND = 2'd2;
    localparam logic [1:0] c_ST_GAP  = 2'd3;

    logic [EV_W-1:0]    r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic [1:0]         r_state;
    logic [EV_W-1:0]    r_pop_word;
    logic [c_SR_W-1:0]  r_shift;
    logic [c_IDX_W-1:0] r_idx;
    logic [7:0]         r_last_byte;
    logic [CNT_W-1:0]   r_drop_count;
    logic               r_overflow;

    logic       w_empty;
    logic       w_full;
    logic       w_push;
    logic       w_pop;
    logic       w_drop;
    logic       w_fire;
    logic [7:0] w_byte;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_FULL_LEVEL);
    assign w_push  = ev_wr && !w_full;
    assign w_drop  = ev_wr && w_full;
    assign w_pop   = (r_state == c_ST_IDLE) && !w_empty;
    // Gated by reset so a request can never escape during the reset cycle.
    assign w_fire  = (r_state == c_ST_SEND) && !tx_busy && !reset;
    // Index 0 is the sync slot; data bytes always come from the top of the shifter.
    assign w_byte  = (r_idx == '0) ? SYNC_BYTE : r_shift[c_SR_W-1 -: 8];

    assign tx_req     = w_fire;
    assign tx_data    = w_fire ? w_byte : r_last_byte;
    assign fifo_full  = w_full;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;
    assign busy       = (r_state != c_ST_IDLE) || !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ev_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (FIFO_AW+1)'(1);
                2'b01:   r_level <= r_level - (FIFO_AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_pop_word  <= '0;
            r_shift     <= '0;
            r_idx       <= '0;
            r_last_byte <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (!w_empty) begin
                        r_pop_word <= r_mem[r_rd_ptr];
                        r_state    <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    r_shift <= c_SR_W'(r_pop_word);
                    r_idx   <= c_FIRST_IDX;
                    r_state <= c_ST_SEND;
                end
                c_ST_SEND: begin
                    if (w_fire) begin
                        r_last_byte <= w_byte;
                        if (r_idx != '0) begin
                            r_shift <= r_shift << 8;
                        end
                        r_state <= c_ST_GAP;
                    end
                end
                c_ST_GAP: begin
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_idx   <= r_idx + c_IDX_W'(1);
                        r_state <= c_ST_SEND;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // A clear wins over a drop arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || clear_drops) begin
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != c_CNT_MAX) begin
                r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_event_stream_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_event_stream_tx                                              |
// | Brief    : Self-checking bench for event_stream_tx (sync and no-sync DUTs) |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_event_stream_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // DUT A: 24-bit events, sync byte, 4-deep FIFO, 2-bit drop counter
    logic        a_reset = 1'b1, a_ev_wr = 1'b0, a_clear = 1'b0, a_force_busy = 1'b0;
    logic [23:0] a_ev_data = '0;
    logic        a_tx_busy, a_tx_req, a_fifo_full, a_overflow, a_busy;
    logic [7:0]  a_tx_data;
    logic [2:0]  a_fifo_level;
    logic [1:0]  a_drop_count;
    int          a_busy_len = 0, a_cnt = 0, a_req_busy = 0;
    logic        a_req_seen;
    logic [7:0]  a_rx_q[$];
    int          a_rx_t[$];
    assign a_tx_busy = a_force_busy || (a_cnt != 0);

    // DUT B: 20-bit events, no sync byte, 8-deep FIFO
    logic        b_reset = 1'b1, b_ev_wr = 1'b0, b_clear = 1'b0;
    logic [19:0] b_ev_data = '0;
    logic        b_tx_busy, b_tx_req, b_fifo_full, b_overflow, b_busy;
    logic [7:0]  b_tx_data;
    logic [3:0]  b_fifo_level;
    logic [15:0] b_drop_count;
    int          b_busy_len = 0, b_cnt = 0, b_req_busy = 0;
    logic        b_req_seen;
    logic [7:0]  b_rx_q[$];
    int          b_rx_t[$];
    assign b_tx_busy = (b_cnt != 0);

    event_stream_tx #(.EV_W(24), .FIFO_AW(2), .SYNC_EN(1'b1), .SYNC_BYTE(8'hA5), .CNT_W(2)) u_a (
        .clk(clk), .reset(a_reset), .ev_wr(a_ev_wr), .ev_data(a_ev_data), .clear_drops(a_clear),
        .tx_busy(a_tx_busy), .tx_req(a_tx_req), .tx_data(a_tx_data), .fifo_full(a_fifo_full),
        .fifo_level(a_fifo_level), .overflow(a_overflow), .drop_count(a_drop_count), .busy(a_busy)
    );

    event_stream_tx #(.EV_W(20), .FIFO_AW(3), .SYNC_EN(1'b0), .SYNC_BYTE(8'hA5), .CNT_W(16)) u_b (
        .clk(clk), .reset(b_reset), .ev_wr(b_ev_wr), .ev_data(b_ev_data), .clear_drops(b_clear),
        .tx_busy(b_tx_busy), .tx_req(b_tx_req), .tx_data(b_tx_data), .fifo_full(b_fifo_full),
        .fifo_level(b_fifo_level), .overflow(b_overflow), .drop_count(b_drop_count), .busy(b_busy)
    );

    // uart_tx stand-ins: capture bytes at negedge, raise busy the cycle after a request.
    always begin
        @(negedge clk);
        a_req_seen = a_tx_req;
        if (a_tx_req) begin
            a_rx_q.push_back(a_tx_data);
            a_rx_t.push_back(cyc);
            if (a_tx_busy) a_req_busy++;
        end
        @(posedge clk);
        #1;
        if (a_req_seen) a_cnt = a_busy_len;
        else if (a_cnt > 0) a_cnt--;
    end

    always begin
        @(negedge clk);
        b_req_seen = b_tx_req;
        if (b_tx_req) begin
            b_rx_q.push_back(b_tx_data);
            b_rx_t.push_back(cyc);
            if (b_tx_busy) b_req_busy++;
        end
        @(posedge clk);
        #1;
        if (b_req_seen) b_cnt = b_busy_len;
        else if (b_cnt > 0) b_cnt--;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // k-th byte on the wire for one event frame
    function automatic logic [7:0] ev_byte(input logic [31:0] ev, input int nb, input bit sync, input int k);
        int j;
        if (sync && k == 0) return 8'hA5;
        j = sync ? k - 1 : k;
        return 8'((ev >> (8 * (nb - 1 - j))) & 32'hFF);
    endfunction

    task automatic a_wait_idle();
        for (int n = 0; n < 500 && (a_busy || a_cnt != 0); n++) tick();
    endtask

    task automatic test_reset();
        a_reset = 1'b1; b_reset = 1'b1;
        repeat (3) tick();
        n_checks++; if (a_tx_req !== 1'b0) begin n_fail++; $display("FAIL reset_tx_req: got %b expected 0", a_tx_req); end
        n_checks++; if (a_tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", a_tx_data); end
        n_checks++; if (a_fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_full: got %b expected 0", a_fifo_full); end
        n_checks++; if (a_fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_level: got %0d expected 0", a_fifo_level); end
        n_checks++; if (a_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", a_overflow); end
        n_checks++; if (a_drop_count !== 2'd0) begin n_fail++; $display("FAIL reset_drop_count: got %0d expected 0", a_drop_count); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        n_checks++; if (b_fifo_level !== 4'd0 || b_fifo_full !== 1'b0 || b_busy !== 1'b0)
            begin n_fail++; $display("FAIL reset_b_state: got level=%0d full=%b busy=%b expected 0/0/0", b_fifo_level, b_fifo_full, b_busy); end
        a_reset = 1'b0; b_reset = 1'b0;
        tick();
    endtask

    task automatic test_single_event();
        logic [7:0] exp [4] = '{8'hA5, 8'h12, 8'hAB, 8'hCD};
        int t0, n;
        a_wait_idle();
        a_busy_len = 0; a_rx_q.delete(); a_rx_t.delete();
        a_ev_wr = 1'b1; a_ev_data = 24'h12ABCD; t0 = cyc;
        tick();
        a_ev_wr = 1'b0;
        n = 0;
        while (a_rx_q.size() < 4 && n < 50) begin tick(); n++; end
        repeat (4) tick();
        n_checks++; if (a_rx_q.size() != 4) begin n_fail++; $display("FAIL t1_count: got %0d bytes expected 4", a_rx_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= a_rx_q.size() || a_rx_q[i] !== exp[i] || a_rx_t[i] != t0 + 3 + 2 * i) begin
                n_fail++;
                $display("FAIL t1_byte[%0d]: got %h @%0d expected %h @%0d", i,
                         (i < a_rx_q.size()) ? a_rx_q[i] : 8'hxx, (i < a_rx_t.size()) ? a_rx_t[i] - t0 : -1, exp[i], 3 + 2 * i);
            end
        end
        n_checks++; if (a_busy !== 1'b0 || a_fifo_level !== 3'd0) begin n_fail++; $display("FAIL t1_idle: got busy=%b level=%0d expected 0/0", a_busy, a_fifo_level); end
    endtask

    task automatic test_sync_off();
        logic [7:0] exp [3] = '{8'h0F, 8'hED, 8'hCB};
        int t0, n;
        b_busy_len = 0; b_rx_q.delete(); b_rx_t.delete();
        b_ev_wr = 1'b1; b_ev_data = 20'hFEDCB; t0 = cyc;
        tick();
        b_ev_wr = 1'b0;
        n = 0;
        while (b_rx_q.size() < 3 && n < 50) begin tick(); n++; end
        repeat (4) tick();
        n_checks++; if (b_rx_q.size() != 3) begin n_fail++; $display("FAIL t2_count: got %0d bytes expected 3", b_rx_q.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= b_rx_q.size() || b_rx_q[i] !== exp[i] || b_rx_t[i] != t0 + 3 + 2 * i) begin
                n_fail++;
                $display("FAIL t2_byte[%0d]: got %h expected %h at +%0d", i,
                         (i < b_rx_q.size()) ? b_rx_q[i] : 8'hxx, exp[i], 3 + 2 * i);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] ev [3];
        logic [7:0]  exp_q[$];
        int n;
        a_wait_idle();
        a_busy_len = 10; a_rx_q.delete(); a_rx_t.delete(); a_req_busy = 0;
        for (int e = 0; e < 3; e++) begin
            ev[e] = 24'($urandom);
            for (int k = 0; k < 4; k++) exp_q.push_back(ev_byte(32'(ev[e]), 3, 1'b1, k));
            a_ev_wr = 1'b1; a_ev_data = ev[e];
            tick();
        end
        a_ev_wr = 1'b0;
        n = 0;
        while (a_rx_q.size() < 12 && n < 400) begin tick(); n++; end
        repeat (15) tick();
        n_checks++; if (a_rx_q.size() != 12) begin n_fail++; $display("FAIL t3_count: got %0d bytes expected 12", a_rx_q.size()); end
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (i >= a_rx_q.size() || a_rx_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL t3_byte[%0d]: got %h expected %h", i, (i < a_rx_q.size()) ? a_rx_q[i] : 8'hxx, exp_q[i]);
            end
        end
        for (int i = 1; i < a_rx_t.size(); i++) begin
            n_checks++;
            if (a_rx_t[i] - a_rx_t[i-1] != 11) begin n_fail++; $display("FAIL t3_spacing[%0d]: got %0d cycles expected 11", i, a_rx_t[i] - a_rx_t[i-1]); end
        end
        n_checks++; if (a_req_busy != 0) begin n_fail++; $display("FAIL t3_req_while_busy: got %0d expected 0", a_req_busy); end
        a_busy_len = 0;
    endtask

    task automatic test_overflow();
        logic [23:0] ev [6];
        logic [7:0]  exp_q[$];
        int n;
        a_wait_idle();
        a_busy_len = 0; a_force_busy = 1'b1; a_rx_q.delete(); a_rx_t.delete();
        for (int e = 0; e < 6; e++) begin
            ev[e] = 24'($urandom);
            if (e < 5) for (int k = 0; k < 4; k++) exp_q.push_back(ev_byte(32'(ev[e]), 3, 1'b1, k));
            a_ev_wr = 1'b1; a_ev_data = ev[e];
            tick();
        end
        a_ev_wr = 1'b0;
        tick();
        n_checks++; if (a_fifo_full !== 1'b1 || a_fifo_level !== 3'd4) begin n_fail++; $display("FAIL t4_full: got full=%b level=%0d expected 1/4", a_fifo_full, a_fifo_level); end
        n_checks++; if (a_drop_count !== 2'd1 || a_overflow !== 1'b1) begin n_fail++; $display("FAIL t4_drop: got count=%0d ovf=%b expected 1/1", a_drop_count, a_overflow); end
        n_checks++; if (a_rx_q.size() != 0) begin n_fail++; $display("FAIL t4_no_req_busy: got %0d bytes expected 0", a_rx_q.size()); end
        a_clear = 1'b1; tick(); a_clear = 1'b0;
        n_checks++; if (a_drop_count !== 2'd0 || a_overflow !== 1'b0) begin n_fail++; $display("FAIL t4_clear: got count=%0d ovf=%b expected 0/0", a_drop_count, a_overflow); end
        // five more writes into a full FIFO saturate the 2-bit counter
        a_ev_wr = 1'b1;
        for (int e = 0; e < 5; e++) begin a_ev_data = 24'($urandom); tick(); end
        a_ev_wr = 1'b0;
        n_checks++; if (a_drop_count !== 2'd3 || a_overflow !== 1'b1 || a_fifo_level !== 3'd4)
            begin n_fail++; $display("FAIL t5_saturate: got count=%0d ovf=%b level=%0d expected 3/1/4", a_drop_count, a_overflow, a_fifo_level); end
        a_clear = 1'b1; a_ev_wr = 1'b1; a_ev_data = 24'h777777;
        tick();
        a_clear = 1'b0; a_ev_wr = 1'b0;
        n_checks++; if (a_drop_count !== 2'd0 || a_overflow !== 1'b0) begin n_fail++; $display("FAIL t5_clear_priority: got count=%0d ovf=%b expected 0/0", a_drop_count, a_overflow); end
        // release the link; write exactly in the IDLE cycle that pops from a full FIFO
        a_force_busy = 1'b0;
        n = 0;
        while (a_rx_q.size() < 4 && n < 50) begin tick(); n++; end
        tick();
        a_ev_wr = 1'b1; a_ev_data = 24'h5A5A5A;
        tick();
        a_ev_wr = 1'b0;
        n_checks++; if (a_drop_count !== 2'd1 || a_overflow !== 1'b1) begin n_fail++; $display("FAIL t5_pop_write_full: got count=%0d ovf=%b expected 1/1", a_drop_count, a_overflow); end
        n = 0;
        while (a_rx_q.size() < 20 && n < 200) begin tick(); n++; end
        repeat (6) tick();
        n_checks++; if (a_rx_q.size() != 20) begin n_fail++; $display("FAIL t4_drain_count: got %0d bytes expected 20", a_rx_q.size()); end
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (i >= a_rx_q.size() || a_rx_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL t4_drain[%0d]: got %h expected %h", i, (i < a_rx_q.size()) ? a_rx_q[i] : 8'hxx, exp_q[i]);
            end
        end
        n_checks++; if (a_fifo_level !== 3'd0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL t4_empty: got level=%0d busy=%b expected 0/0", a_fifo_level, a_busy); end
        a_clear = 1'b1; tick(); a_clear = 1'b0;
    endtask

    task automatic test_reset_mid_event();
        logic [23:0] e1, e2, e3;
        int n, t0;
        a_wait_idle();
        a_busy_len = 0; a_rx_q.delete(); a_rx_t.delete();
        e1 = 24'($urandom); e2 = 24'($urandom); e3 = 24'($urandom);
        a_ev_wr = 1'b1; a_ev_data = e1; tick();
        a_ev_data = e2; tick();
        a_ev_wr = 1'b0;
        n = 0;
        while (a_rx_q.size() < 2 && n < 50) begin tick(); n++; end
        tick();
        n_checks++; if (a_fifo_level !== 3'd1) begin n_fail++; $display("FAIL t6_pre_level: got %0d expected 1", a_fifo_level); end
        a_reset = 1'b1;
        #1;
        n_checks++; if (a_tx_req !== 1'b0) begin n_fail++; $display("FAIL t6_req_in_reset: got %b expected 0", a_tx_req); end
        tick();
        n_checks++; if (a_tx_req !== 1'b0 || a_fifo_level !== 3'd0 || a_busy !== 1'b0)
            begin n_fail++; $display("FAIL t6_after_reset: got req=%b level=%0d busy=%b expected 0/0/0", a_tx_req, a_fifo_level, a_busy); end
        a_reset = 1'b0;
        repeat (20) tick();
        n_checks++; if (a_rx_q.size() != 2 || a_rx_q[0] !== 8'hA5 || a_rx_q[1] !== e1[23:16])
            begin n_fail++; $display("FAIL t6_partial: got %0d bytes expected 2 (A5,%h)", a_rx_q.size(), e1[23:16]); end
        a_rx_q.delete(); a_rx_t.delete();
        a_ev_wr = 1'b1; a_ev_data = e3; t0 = cyc; tick(); a_ev_wr = 1'b0;
        n = 0;
        while (a_rx_q.size() < 4 && n < 50) begin tick(); n++; end
        n_checks++; if (a_rx_q.size() != 4 || a_rx_t[0] != t0 + 3) begin n_fail++; $display("FAIL t6_new_count: got %0d bytes expected 4 starting at +3", a_rx_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= a_rx_q.size() || a_rx_q[i] !== ev_byte(32'(e3), 3, 1'b1, i)) begin
                n_fail++; $display("FAIL t6_new[%0d]: got %h expected %h", i, (i < a_rx_q.size()) ? a_rx_q[i] : 8'hxx, ev_byte(32'(e3), 3, 1'b1, i));
            end
        end
    endtask

    task automatic test_random();
        logic [7:0]  exp_q[$];
        logic [19:0] d;
        int written, n;
        written = 0;
        b_busy_len = $urandom_range(0, 3);
        b_rx_q.delete(); b_rx_t.delete(); b_req_busy = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 1) == 1 && (written - b_rx_q.size() / 3) < 8) begin
                d = 20'($urandom);
                for (int k = 0; k < 3; k++) exp_q.push_back(ev_byte(32'(d), 3, 1'b0, k));
                b_ev_wr = 1'b1; b_ev_data = d;
                written++;
            end else begin
                b_ev_wr = 1'b0;
            end
            tick();
        end
        b_ev_wr = 1'b0;
        n = 0;
        while (b_rx_q.size() < exp_q.size() && n < 3000) begin tick(); n++; end
        repeat (10) tick();
        n_checks++; if (b_rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d bytes expected %0d", b_rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= b_rx_q.size() || b_rx_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rnd_byte[%0d]: got %h expected %h", i, (i < b_rx_q.size()) ? b_rx_q[i] : 8'hxx, exp_q[i]);
            end
        end
        n_checks++; if (b_drop_count !== 16'd0 || b_overflow !== 1'b0) begin n_fail++; $display("FAIL rnd_no_drop: got count=%0d ovf=%b expected 0/0", b_drop_count, b_overflow); end
        n_checks++; if (b_req_busy != 0) begin n_fail++; $display("FAIL rnd_req_while_busy: got %0d expected 0", b_req_busy); end
        n_checks++; if (b_busy !== 1'b0 || b_fifo_level !== 4'd0) begin n_fail++; $display("FAIL rnd_idle: got busy=%b level=%0d expected 0/0", b_busy, b_fifo_level); end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_sync_off();
        test_back_to_back();
        test_overflow();
        test_reset_mid_event();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
